// File: rtl/instr_fetch_ctrl_pkg.sv
// rtl/instr_fetch_ctrl_pkg.sv - shared PC adder select codes and fetch state encoding
package instr_fetch_ctrl_pkg;

  localparam logic [1:0] PC_PLUS_4    = 2'b00;
  localparam logic [1:0] PC_PLUS_IMM  = 2'b01;
  localparam logic [1:0] RS1_PLUS_IMM = 2'b10;
  localparam logic [1:0] PC_PLUS_0    = 2'b11;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_WAIT  = 2'b01,
    ST_DROP  = 2'b10,
    ST_HOLD  = 2'b11
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - PC register owner, single-outstanding imem fetch, IF/ID holding register
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc,
  output logic [1:0]  pc_src,
  input  logic [31:0] next_pc,
  input  logic        redirect_valid,
  input  logic        redirect_jalr,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  if_instr_q, if_instr_d;
  logic [31:0]  if_pc_q, if_pc_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        // A redirect without acceptance just retargets the still-unaccepted request.
        if (imem_req_ready) begin
          state_d = redirect_valid ? ST_DROP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          state_d = redirect_valid ? ST_FETCH : ST_HOLD;
        end else if (redirect_valid) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (imem_rsp_valid) begin
          state_d = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (redirect_valid || if_ready) begin
          state_d = ST_FETCH;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    pc_src         = PC_PLUS_0;
    imem_req_valid = 1'b0;
    if_valid       = 1'b0;
    if (!rst) begin
      imem_req_valid = (state_q == ST_FETCH);
      if_valid       = (state_q == ST_HOLD);
      if (redirect_valid) begin
        pc_src = redirect_jalr ? RS1_PLUS_IMM : PC_PLUS_IMM;
      end else if (state_q == ST_HOLD && if_ready) begin
        pc_src = PC_PLUS_4;
      end
    end
  end

  always_comb begin
    pc_d       = rst ? RESET_PC : next_pc;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if (rst) begin
      if_instr_d = 32'h0;
      if_pc_d    = 32'h0;
    end else if (state_q == ST_WAIT && imem_rsp_valid && !redirect_valid) begin
      if_instr_d = imem_rsp_data;
      if_pc_d    = pc_q;
    end
  end

  always_ff @(posedge clk) begin
    pc_q       <= pc_d;
    if_instr_q <= if_instr_d;
    if_pc_q    <= if_pc_d;
  end

  assign pc            = pc_q;
  assign imem_req_addr = pc_q;
  assign if_instr      = if_instr_q;
  assign if_pc         = if_pc_q;

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Instruction-fetch controller that owns the program counter register and drives the `pc_src` select into the PC adder, then registers the adder's `next_pc` result every cycle. It issues one instruction-memory request at a time and holds the returned instruction for decode. It also applies branch/JALR redirects from execute, squashing any in-flight or held instruction. It sits between the PC adder, instruction memory and the IF/ID boundary.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `pc`  out  32  current PC register, feeds PC adder
- `pc_src`  out  2  PC adder select: 00 PC+4, 01 PC+imm, 10 rs1+imm, 11 hold
- `next_pc`  in  32  PC adder result, loaded into `pc` every cycle
- `redirect_valid`  in  1  execute resolved a taken branch/jump this cycle
- `redirect_jalr`  in  1  qualifies `redirect_valid`: 1 = JALR (rs1+imm), 0 = PC+imm
- `imem_req_valid`  out  1  fetch request
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  32  equals `pc`
- `imem_rsp_valid`  in  1  response strobe, one per accepted request, in order
- `imem_rsp_data`  in  32  instruction word
- `if_valid`  out  1  instruction available to decode
- `if_ready`  in  1  decode accepts (low = stall)
- `if_instr`  out  32  held instruction
- `if_pc`  out  32  PC of held instruction

## Operation
- States:
  - FETCH: `imem_req_valid`=1.
  - WAIT: one request outstanding.
  - DROP: outstanding response is to be discarded.
  - HOLD: `if_valid`=1.
- `pc_src` (combinational), in priority order:
  1. `redirect_valid` → 10 if `redirect_jalr`, else 01.
  2. Otherwise, HOLD with `if_ready` → 00.
  3. Otherwise → 11.
- `pc <= next_pc` every non-reset cycle. Because `pc_src`=11 yields `pc`, the PC holds when `pc_src`=11.
- FETCH:
  - `imem_req_ready` with no redirect → WAIT.
  - `imem_req_ready` with a redirect in the same cycle → DROP, since the accepted request is for the stale PC.
  - Redirect without `imem_req_ready` → stay in FETCH. An unaccepted request is not binding, so `imem_req_addr` follows the new `pc` next cycle.
- WAIT:
  - `imem_rsp_valid` with no redirect → capture `if_instr <= imem_rsp_data` and `if_pc <= pc`, go to HOLD.
  - `imem_rsp_valid` with a redirect → discard the response, go to FETCH.
  - Redirect without a response → DROP.
- DROP: `imem_rsp_valid` → FETCH, data discarded. Further redirects in DROP only update `pc`.
- HOLD:
  - Redirect → squash (`if_valid` falls next cycle), go to FETCH. The redirect wins even when `if_ready`=1 in the same cycle; that instruction is still considered consumed by decode.
  - `if_ready` with no redirect → FETCH, PC advances by 4.
- `if_instr` and `if_pc` remain stable while `if_valid`=1.
- Responses arriving in FETCH or HOLD are a protocol violation. They are ignored; the bench asserts this never happens.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, state=FETCH.
  - `if_valid`=0, `if_instr`=0, `if_pc`=0.
  - `pc_src`=11 while `rst`=1.
  - `imem_req_valid`=0 while `rst`=1, and 1 from the first cycle after `rst` deasserts.
- Reset mid-operation returns to FETCH immediately and abandons any outstanding request. Instruction memory is reset on the same `rst`.
- Zero-wait memory (ready=1, response the cycle after accept) with `if_ready`=1 gives this cycle sequence:
  - cycle 0: FETCH, request accepted
  - cycle 1: WAIT, response arrives
  - cycle 2: HOLD, `if_valid`=1, accepted
  - cycle 3: FETCH at PC+4
- Steady-state throughput: 1 instruction per 3 cycles.
- Redirect latency: the target appears on `pc` and `imem_req_addr` one cycle after `redirect_valid`.
- `redirect_valid` is a single-cycle pulse; back-to-back pulses are legal and the last one wins.

## Structure
- Shared package:
  - `pc_src` localparams PC_PLUS_4, PC_PLUS_IMM, RS1_PLUS_IMM, PC_PLUS_0, also used by the PC adder.
  - Fetch state encoding.
- No sub-module. The PC adder is instantiated beside this block at the fetch-stage top; this block does no PC arithmetic itself.

## Test plan
- Reset with `RESET_PC`=32'h100, zero-wait memory, `if_ready`=1 → decode receives PCs 0x100, 0x104, 0x108, one every 3 cycles.
- `if_ready`=0 for 5 cycles in HOLD at PC 0x104 → `if_valid` stays 1, `if_instr`/`if_pc` stable, `pc_src`=11, `pc` stays 0x104.
- Redirect (PC+imm, imm=0x40) during WAIT at PC 0x104 → response dropped via DROP, next request address 0x144, decode never sees 0x104's word.
- JALR redirect (rs1+imm=0x2000) in HOLD with `if_ready`=1 in the same cycle → `pc_src`=10, next fetch 0x2000, no PC+4 fetch issued.
- `imem_req_ready` held low 4 cycles, redirect to 0x300 on cycle 2 → request address changes to 0x300, single request accepted, no DROP.
- `rst` asserted while in WAIT → next cycle `pc`=`RESET_PC`, `if_valid`=0, FETCH resumes after deassert.
